// File: rtl/uart_tx_arb.sv
`timescale 1ns/1ps
// uart_tx_arb: round-robin byte arbiter with packet locking in front of a shared UART TX,
// plus quiet-line mode sequencing. Define UARTP_ARB_TIMEOUT_EN to add the idle-lock timeout.
module uart_tx_arb #(
  parameter int N_REQ        = 2,
  parameter int DATA_W       = 8,
  parameter int MODE_W       = 4,
  parameter int RESET_MODE   = 1,
  parameter int GUARD        = 16,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [MODE_W-1:0]       mode_req,
  input  logic                    mode_req_valid,
  output logic [MODE_W-1:0]       mode_out,
  output logic                    mode_busy,
  output logic [IDW-1:0]          grant_id
);
  localparam int GW = $clog2(GUARD + 1);

  if (N_REQ < 1 || N_REQ > 8 || GUARD < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arb: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_LOCK, S_MODE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic                last_q, last_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [MODE_W-1:0]   pend_mode_q, pend_mode_d;
  logic                pending_q, pending_d;
  logic [GW-1:0]       guard_q, guard_d;
  logic [N_REQ-1:0]    ready;
  logic [IDW-1:0]      winner;
  logic                found;
  logic [IDW-1:0]      cap_idx;
  logic [DATA_W-1:0]   cap_data;
`ifdef UARTP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0]       lock_cnt_q, lock_cnt_d;
`endif

  // First valid requester at or above the rr pointer, wrapping around.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign cap_idx  = (state_q == S_LOCK) ? grant_q : winner;
  assign cap_data = req_data[int'(cap_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    last_d      = last_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pending_d   = pending_q;
    guard_d     = guard_q;
    ready       = '0;
`ifdef UARTP_ARB_TIMEOUT_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    if (mode_req_valid) begin
      pending_d   = 1'b1;
      pend_mode_d = mode_req;
    end
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d = S_MODE;
          guard_d = '0;
        end else if (found) begin
          ready[winner] = 1'b1;
          tx_data_d     = cap_data;
          tx_valid_d    = 1'b1;
          grant_d       = winner;
          last_d        = req_last[winner];
          rr_d          = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
          state_d       = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = last_q ? S_IDLE : S_LOCK;
`ifdef UARTP_ARB_TIMEOUT_EN
          lock_cnt_d = '0;
`endif
        end
      end
      S_LOCK: begin
        // Only the packet owner may deliver; the rr pointer is left alone while locked.
        if (req_valid[grant_q]) begin
          ready[grant_q] = 1'b1;
          tx_data_d      = cap_data;
          tx_valid_d     = 1'b1;
          last_d         = req_last[grant_q];
          state_d        = S_SEND;
`ifdef UARTP_ARB_TIMEOUT_EN
          lock_cnt_d     = '0;
        end else if (lock_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d        = S_IDLE;
          lock_cnt_d     = '0;
        end else begin
          lock_cnt_d     = lock_cnt_q + 1'b1;
`endif
        end
      end
      S_MODE: begin
        if (!tx_ready) begin
          guard_d = '0;
        end else if (guard_q == GW'(GUARD - 1)) begin
          // A strobe landing on the apply cycle survives as the next pending request.
          mode_d    = pend_mode_q;
          pending_d = mode_req_valid;
          guard_d   = '0;
          state_d   = S_IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      grant_q     <= '0;
      rr_q        <= '0;
      last_q      <= 1'b0;
      mode_q      <= MODE_W'(RESET_MODE);
      pend_mode_q <= '0;
      pending_q   <= 1'b0;
      guard_q     <= '0;
`ifdef UARTP_ARB_TIMEOUT_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pending_q   <= pending_d;
      guard_q     <= guard_d;
`ifdef UARTP_ARB_TIMEOUT_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign req_ready = ready;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign grant_id  = grant_q;
  assign mode_out  = mode_q;
  assign mode_busy = pending_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
`timescale 1ns/1ps
// Bench for uart_tx_arb: expected TX bytes queued as stimulus is driven, popped on each TX accept.
module tb_uart_tx_arb;
  localparam int N_REQ        = 2;
  localparam int DATA_W       = 8;
  localparam int MODE_W       = 4;
  localparam int GUARD        = 6;
  localparam int LOCK_TIMEOUT = 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_last = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_valid;
  logic                    tx_ready = 1'b0;
  logic [MODE_W-1:0]       mode_req = '0;
  logic                    mode_req_valid = 1'b0;
  logic [MODE_W-1:0]       mode_out;
  logic                    mode_busy;
  logic [0:0]              grant_id;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .MODE_W(MODE_W), .RESET_MODE(1),
    .GUARD(GUARD), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .mode_out(mode_out), .mode_busy(mode_busy), .grant_id(grant_id)
  );

  // TX-side scoreboard: a handshake visible at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: tx_data=%h sent, required no byte", tx_data);
      end else begin
        logic [DATA_W-1:0] exp;
        exp = sb.pop_front();
        if (tx_data !== exp) $display("FAIL sb_byte: tx_data=%h, required %h", tx_data, exp);
        else n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DATA_W-1:0] d, input logic v, input logic l);
    req_data[i*DATA_W +: DATA_W] = d;
    req_valid[i] = v;
    req_last[i]  = l;
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (req_ready == '0) begin
      if (t == 30) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (mode_out !== 4'd1 || tx_valid !== 1'b0 || req_ready !== 2'b00 || mode_busy !== 1'b0)
        $display("FAIL reset_idle cyc %0d: mode_out=%h tx_valid=%b req_ready=%b mode_busy=%b, required 1 0 00 0",
                 i, mode_out, tx_valid, req_ready, mode_busy);
      else n_pass++;
    end
    n_checks++;
    if (grant_id !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL reset_regs: grant_id=%0d tx_data=%h, required 0 00", grant_id, tx_data);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp_rdy;
    step();
    set_req(0, 8'h41, 1'b1, 1'b1);
    set_req(1, 8'h42, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) sb.push_back((i % 2 == 0) ? 8'h41 : 8'h42);
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready(ok);
      n_checks++;
      if (!ok || req_ready !== exp_rdy)
        $display("FAIL rr_grant %0d: req_ready=%b, required %b", i, req_ready, exp_rdy);
      else n_pass++;
      step();
      tx_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00 || tx_valid !== 1'b1 || grant_id !== exp_rdy[1])
        $display("FAIL rr_pulse %0d: req_ready=%b tx_valid=%b grant_id=%0d, required 00 1 %0d",
                 i, req_ready, tx_valid, grant_id, exp_rdy[1]);
      else n_pass++;
      step();
      tx_ready = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_lock();
    bit ok;
    set_req(1, 8'h99, 1'b1, 1'b1);
    for (int b = 0; b < 3; b++) sb.push_back(8'h10 + 8'(b));
    sb.push_back(8'h99);
    for (int b = 0; b < 3; b++) begin
      set_req(0, 8'h10 + 8'(b), 1'b1, (b == 2));
      wait_ready(ok);
      n_checks++;
      if (!ok || req_ready !== 2'b01)
        $display("FAIL lock_grant %0d: req_ready=%b, required 01", b, req_ready);
      else n_pass++;
      step();
      if (b == 2) req_valid[0] = 1'b0;
      tx_ready = 1'b1;
      @(negedge clk);
      step();
      tx_ready = 1'b0;
    end
    wait_ready(ok);
    n_checks++;
    if (!ok || req_ready !== 2'b10)
      $display("FAIL lock_release: req_ready=%b, required 10", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    tx_ready  = 1'b1;
    @(negedge clk);
    step();
    tx_ready = 1'b0;
    n_checks++;
    if (sb.size() != 0) $display("FAIL lock_drain: %0d bytes outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_mode_guard();
    bit ok;
    int n;
    set_req(0, 8'hC3, 1'b1, 1'b1);
    sb.push_back(8'hC3);
    wait_ready(ok);
    step();
    req_valid      = '0;
    mode_req       = 4'h3;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (!ok || mode_out !== 4'h1 || mode_busy !== 1'b1 || tx_valid !== 1'b1)
      $display("FAIL mode_hold_send: mode_out=%h busy=%b tx_valid=%b, required 1 1 1", mode_out, mode_busy, tx_valid);
    else n_pass++;
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    set_req(1, 8'h77, 1'b1, 1'b1);
    sb.push_back(8'h77);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00)
      $display("FAIL mode_priority: req_ready=%b, required 00", req_ready);
    else n_pass++;
    repeat (3) begin
      step();
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00 || mode_out !== 4'h1)
        $display("FAIL mode_no_grant: req_ready=%b mode_out=%h, required 00 1", req_ready, mode_out);
      else n_pass++;
    end
    step();
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    repeat (2) step();
    n_checks++;
    if (mode_out !== 4'h1 || mode_busy !== 1'b1)
      $display("FAIL mode_guard_restart: mode_out=%h busy=%b, required 1 1", mode_out, mode_busy);
    else n_pass++;
    tx_ready = 1'b1;
    n = 0;
    while (mode_out !== 4'h3 && n < 40) begin
      step();
      n++;
    end
    tx_ready = 1'b0;
    n_checks++;
    if (n != GUARD || mode_busy !== 1'b0)
      $display("FAIL mode_guard_len: applied after %0d cycles busy=%b, required %0d 0", n, mode_busy, GUARD);
    else n_pass++;
    wait_ready(ok);
    step();
    req_valid = '0;
    tx_ready  = 1'b1;
    @(negedge clk);
    step();
    tx_ready = 1'b0;
    n_checks++;
    if (!ok || sb.size() != 0)
      $display("FAIL mode_drain: ok=%0d outstanding=%0d, required 1 0", ok, sb.size());
    else n_pass++;
  endtask

  task automatic test_mode_overwrite();
    bit saw2;
    saw2 = 1'b0;
    step();
    mode_req       = 4'h2;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    repeat (2) step();
    mode_req       = 4'h5;
    mode_req_valid = 1'b1;
    step();
    mode_req_valid = 1'b0;
    n_checks++;
    if (mode_out !== 4'h3 || mode_busy !== 1'b1)
      $display("FAIL ovw_pending: mode_out=%h busy=%b, required 3 1", mode_out, mode_busy);
    else n_pass++;
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mode_out === 4'h2) saw2 = 1'b1;
    end
    n_checks++;
    if (saw2 || mode_out !== 4'h5 || mode_busy !== 1'b0)
      $display("FAIL ovw_final: saw2=%0d mode_out=%h busy=%b, required 0 5 0", saw2, mode_out, mode_busy);
    else n_pass++;
    step();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_req(0, 8'hEE, 1'b1, 1'b1);
    wait_ready(ok);
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (!ok || tx_valid !== 1'b1 || tx_data !== 8'hEE)
      $display("FAIL rstmid_send: tx_valid=%b tx_data=%h, required 1 ee", tx_valid, tx_data);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || mode_out !== 4'h1 || mode_busy !== 1'b0)
      $display("FAIL rstmid_async: tx_valid=%b tx_data=%h mode_out=%h busy=%b, required 0 00 1 0",
               tx_valid, tx_data, mode_out, mode_busy);
    else n_pass++;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_lock_timeout();
    bit ok;
    bit seen;
    int n;
    set_req(0, 8'hAA, 1'b1, 1'b0);
    sb.push_back(8'hAA);
    wait_ready(ok);
    n_checks++;
    if (!ok || req_ready !== 2'b01)
      $display("FAIL tmo_grant: req_ready=%b, required 01", req_ready);
    else n_pass++;
    step();
    req_valid[0] = 1'b0;
    set_req(1, 8'h55, 1'b1, 1'b1);
    tx_ready = 1'b1;
    @(negedge clk);
    step();
`ifdef UARTP_ARB_TIMEOUT_EN
    sb.push_back(8'h55);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready[1] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || n != LOCK_TIMEOUT + 1)
      $display("FAIL tmo_release: req1 granted at cycle %0d seen=%0d, required %0d 1", n, seen, LOCK_TIMEOUT + 1);
    else n_pass++;
    step();
    req_valid = '0;
    @(negedge clk);
    step();
`else
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (req_ready[1] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen)
      $display("FAIL tmo_held: req_ready[1] asserted within %0d cycles, required never", n);
    else n_pass++;
`endif
    tx_ready = 1'b0;
    n_checks++;
    if (sb.size() != 0) $display("FAIL tmo_drain: %0d bytes outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_mode_guard();
    test_mode_overwrite();
    test_reset_mid();
    test_lock_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
